// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the retire-trace transmitter.
// TRACE_CHECKSUM_EN appends an XOR checksum byte to every packet.
package riscv_trace_pkg;

    localparam logic [7:0] TRACE_SYNC  = 8'hA5;
    localparam int         TRACE_REC_W = 101;

`ifdef TRACE_CHECKSUM_EN
    localparam int TRACE_PKT_BYTES = 15;
`else
    localparam int TRACE_PKT_BYTES = 14;
`endif

    localparam int TRACE_PKT_W = TRACE_PKT_BYTES * 8;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_rec_t;

    // Lays a record out as the packet, first byte in the top bits.
    function automatic logic [TRACE_PKT_W-1:0] trace_pack(
        input trace_rec_t r
    );
        logic [111:0] body;
`ifdef TRACE_CHECKSUM_EN
        logic [7:0] sum;
`endif
        body = {TRACE_SYNC, r.pc, r.instr, 3'b000, r.rd, r.data};
`ifdef TRACE_CHECKSUM_EN
        sum = '0;
        for (int i = 0; i < 13; i++) begin
            sum = sum ^ body[i*8 +: 8];
        end
        return {body, sum};
`else
        return body;
`endif
    endfunction

endpackage

// File: rtl/riscv_trace_if.sv
// Byte stream valid/ready link between the trace transmitter and a sink.
// master drives bytes, slave accepts them.
interface riscv_trace_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

endinterface

// File: rtl/riscv_trace_fifo.sv
// Synchronous record FIFO; full/empty derive from the registered count,
// so a push while full is refused even if a pop happens that cycle.
module riscv_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 101
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_trace_tx.sv
// Retire-trace transmitter: buffers write-back records and streams each
// as a sync-prefixed byte packet (checksum byte when TRACE_CHECKSUM_EN).
module riscv_trace_tx
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [31:0]       wb_pc,
    input  logic [31:0]       wb_instr,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    riscv_trace_if.master     tx,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int IDX_W = $clog2(TRACE_PKT_BYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(TRACE_PKT_BYTES - 1);

    trace_state_e           state_q;
    trace_state_e           state_d;
    logic [TRACE_PKT_W-1:0] pkt_q;
    logic [TRACE_PKT_W-1:0] pkt_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic                   pop;
    logic                   full;
    logic                   empty;
    trace_rec_t             wr_rec;
    trace_rec_t             head;

    assign wr_rec = '{
        pc:    wb_pc,
        instr: wb_instr,
        rd:    wb_rd,
        data:  wb_data
    };

    riscv_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wb_valid),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign tx.tx_valid = (state_q == ST_SEND);
    assign tx.tx_data  = pkt_q[TRACE_PKT_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pkt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    pkt_d   = trace_pack(head);
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx.tx_ready) begin
                    if (idx_q == LAST) begin
                        // Chain straight into the next record to avoid a bubble.
                        if (!empty) begin
                            pop   = 1'b1;
                            pkt_d = trace_pack(head);
                            idx_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        pkt_d = pkt_q << 8;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (wb_valid && full) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_trace_tx.sv
// Randomised bench for riscv_trace_tx against a transaction-level model:
// byte scoreboard, occupancy/drop model and a golden packet for one record.
module tb_riscv_trace_tx;
    import riscv_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int NB    = TRACE_PKT_BYTES;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_instr;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    riscv_trace_if tx ();

    riscv_trace_tx #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_pc    (wb_pc),
        .wb_instr (wb_instr),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .tx       (tx),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: records waiting in the FIFO, packet in flight, bytes left.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         m_pend;
    int         m_rem;
    bit         m_busy;
    bit         m_ovf;
    int         m_drops;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void add_packet(
        logic [31:0] pc, logic [31:0] instr,
        logic [4:0] rd, logic [31:0] data
    );
        logic [7:0] b [15];
        logic [7:0] s;
        b[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            b[1+k]  = 8'(pc    >> (24 - 8*k));
            b[5+k]  = 8'(instr >> (24 - 8*k));
            b[10+k] = 8'(data  >> (24 - 8*k));
        end
        b[9] = {3'b000, rd};
        s = 8'h00;
        for (int i = 1; i < 14; i++) s = s ^ b[i];
        b[14] = s;
        for (int i = 0; i < NB; i++) exp_q.push_back(b[i]);
    endfunction

    task automatic cycle(
        bit v, logic [31:0] pc, logic [31:0] instr,
        logic [4:0] rd, logic [31:0] data, bit rdy
    );
        bit         hs;
        bit         last;
        bit         full;
        bit         stalled;
        logic [7:0] pd;
        wb_valid    = v;
        wb_pc       = pc;
        wb_instr    = instr;
        wb_rd       = rd;
        wb_data     = data;
        tx.tx_ready = rdy;
        if (tx.tx_valid && rdy) begin
            got_q.push_back(tx.tx_data);
            if (exp_q.size() == 0) check("spurious_byte", 1, 0);
            else check("byte", tx.tx_data, exp_q.pop_front());
        end
        stalled = tx.tx_valid && !rdy;
        pd      = tx.tx_data;
        hs   = m_busy && rdy;
        last = hs && (m_rem == 1);
        full = (m_pend == DEPTH);
        if (v && full) begin
            m_ovf = 1'b1;
            if (m_drops < (2**CNT_W - 1)) m_drops++;
        end
        if ((!m_busy || last) && m_pend > 0) begin
            m_pend--;
            m_busy = 1'b1;
            m_rem  = NB;
        end else if (last) begin
            m_busy = 1'b0;
        end else if (hs) begin
            m_rem--;
        end
        if (v && !full) begin
            m_pend++;
            add_packet(pc, instr, rd, data);
        end
        @(posedge clk);
        @(negedge clk);
        check("tx_valid", tx.tx_valid, m_busy);
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drops);
        if (stalled) check("hold_data", tx.tx_data, pd);
    endtask

    task automatic idle(int n, int mode);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 0, 0,
                  mode == 2 ? 1'($urandom) : 1'(mode));
        end
    endtask

    task automatic push_rand(bit rdy);
        cycle(1, $urandom, $urandom, 5'($urandom), $urandom, rdy);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        wb_valid    = 1'b0;
        tx.tx_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        m_pend  = 0;
        m_rem   = 0;
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
        exp_q.delete();
        got_q.delete();
        check("rst_valid", tx.tx_valid, 0);
        check("rst_data", tx.tx_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
    endtask

    task automatic check_golden(string tag);
        logic [7:0] golden [15];
        golden = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04,
                   8'h00, 8'h50, 8'h00, 8'h93, 8'h01,
                   8'h00, 8'h00, 8'h00, 8'h05, 8'hC3};
        check({tag, "_len"}, got_q.size(), NB);
        for (int i = 0; i < NB && i < got_q.size(); i++) begin
            check(tag, got_q[i], golden[i]);
        end
    endtask

    initial begin
        reset       = 1'b1;
        wb_valid    = 1'b0;
        wb_pc       = '0;
        wb_instr    = '0;
        wb_rd       = '0;
        wb_data     = '0;
        tx.tx_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single record, sink always ready.
        cycle(1, 32'h4, 32'h0050_0093, 5'd1, 32'h5, 1'b1);
        idle(NB + 4, 1);
        check_golden("pkt_single");
        check("drained1", exp_q.size(), 0);

        // Three back-to-back records.
        for (int i = 0; i < 3; i++) push_rand(1'b1);
        idle(3*NB + 4, 1);
        check("drained3", exp_q.size(), 0);

        // Same record under random backpressure.
        got_q.delete();
        cycle(1, 32'h4, 32'h0050_0093, 5'd1, 32'h5, 1'($urandom));
        idle(6*NB, 2);
        check_golden("pkt_bp");
        check("drained_bp", exp_q.size(), 0);

        // Overflow with sink stalled, then release.
        for (int i = 0; i < 10; i++) push_rand(1'b0);
        idle(4, 0);
        idle(10*NB + 4, 1);
        check("drained_ovf", exp_q.size(), 0);

        // Random traffic and random backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(2) == 0), $urandom, $urandom,
                  5'($urandom), $urandom, 1'($urandom));
        end
        idle(20*NB, 1);
        check("drained_rand", exp_q.size(), 0);

        // Reset in the middle of a packet.
        do_reset();
        for (int i = 0; i < 12; i++) push_rand(1'b0);
        idle(6, 1);
        do_reset();
        idle(20, 1);
        cycle(1, 32'h4, 32'h0050_0093, 5'd1, 32'h5, 1'b1);
        idle(NB + 4, 1);
        check_golden("pkt_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
